// File: rtl/branch_predict_resolve_if.sv
// Resolve/lookup bus between the fetch/execute pipeline and the branch resolve unit.
// master drives requests and pipeline control; slave is the resolve unit.
interface branch_predict_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic [XLEN-1:0]  pred_pc_w_i;
  logic             pred_taken_w_o_h;
  logic             valid_w_i_h;
  logic [2:0]       funct_3_w_i;
  logic [XLEN-1:0]  rs1_w_i;
  logic [XLEN-1:0]  rs2_w_i;
  logic [XLEN-1:0]  pc_w_i;
  logic             pred_taken_w_i_h;
  logic             stall_w_i_h;
  logic             flush_w_i_h;
  logic             ready_w_o_h;
  logic             res_valid_w_o_h;
  logic             taken_w_o_h;
  logic             mispredict_w_o_h;
  logic             illegal_w_o_h;
  logic [CNT_W-1:0] mispredict_cnt_w_o;

  modport master (
    output pred_pc_w_i, valid_w_i_h, funct_3_w_i, rs1_w_i, rs2_w_i, pc_w_i,
           pred_taken_w_i_h, stall_w_i_h, flush_w_i_h,
    input  pred_taken_w_o_h, ready_w_o_h, res_valid_w_o_h, taken_w_o_h,
           mispredict_w_o_h, illegal_w_o_h, mispredict_cnt_w_o
  );

  modport slave (
    input  pred_pc_w_i, valid_w_i_h, funct_3_w_i, rs1_w_i, rs2_w_i, pc_w_i,
           pred_taken_w_i_h, stall_w_i_h, flush_w_i_h,
    output pred_taken_w_o_h, ready_w_o_h, res_valid_w_o_h, taken_w_o_h,
           mispredict_w_o_h, illegal_w_o_h, mispredict_cnt_w_o
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Branch resolve unit: evaluates branch conditions, registers the outcome one cycle
// later, trains a table of 2-bit counters and counts mispredicts.
module branch_predict_resolve #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 16,
  parameter int unsigned CNT_W     = 16
) (
  input logic                     clk_w_i,
  input logic                     rst_w_i_l,
  branch_predict_resolve_if.slave bp
);
  localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

  logic [BHT_DEPTH-1:0][1:0] bht_q;
  logic                      res_valid_q;
  logic                      taken_q;
  logic                      mispredict_q;
  logic                      illegal_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [IDX_W-1:0] pred_idx_c;
  logic [IDX_W-1:0] upd_idx_c;
  logic             eq_c;
  logic             lts_c;
  logic             ltu_c;
  logic             legal_c;
  logic             taken_c;
  logic             mispredict_c;
  logic [1:0]       ctr_c;
  logic [1:0]       ctr_next_c;
  logic             unused_pc_bits_c;

  assign pred_idx_c = bp.pred_pc_w_i[IDX_W+1:2];
  assign upd_idx_c  = bp.pc_w_i[IDX_W+1:2];

  // Only the word-index bits of either PC feed the table.
  assign unused_pc_bits_c = ^{bp.pc_w_i[XLEN-1:IDX_W+2], bp.pc_w_i[1:0],
                              bp.pred_pc_w_i[XLEN-1:IDX_W+2], bp.pred_pc_w_i[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not visible yet.
  assign bp.pred_taken_w_o_h = bht_q[pred_idx_c][1];
  assign bp.ready_w_o_h      = ~bp.stall_w_i_h;

  always_comb begin
    eq_c       = (bp.rs1_w_i == bp.rs2_w_i);
    lts_c      = ($signed(bp.rs1_w_i) < $signed(bp.rs2_w_i));
    ltu_c      = (bp.rs1_w_i < bp.rs2_w_i);
    legal_c    = 1'b1;
    taken_c    = 1'b0;
    case (bp.funct_3_w_i)
      3'b000:  taken_c = eq_c;
      3'b001:  taken_c = ~eq_c;
      3'b100:  taken_c = lts_c;
      3'b101:  taken_c = ~lts_c;
      3'b110:  taken_c = ltu_c;
      3'b111:  taken_c = ~ltu_c;
      default: legal_c = 1'b0;
    endcase
    mispredict_c = legal_c & (taken_c ^ bp.pred_taken_w_i_h);

    // Saturating 2-bit counter step toward the resolved direction.
    ctr_c      = bht_q[upd_idx_c];
    ctr_next_c = ctr_c;
    if (taken_c) begin
      if (ctr_c != 2'b11) ctr_next_c = ctr_c + 2'd1;
    end else if (ctr_c != 2'b00) begin
      ctr_next_c = ctr_c - 2'd1;
    end
  end

  // Flush wins over stall; stall freezes results, table and counter.
  always_ff @(posedge clk_w_i or negedge rst_w_i_l) begin
    if (!rst_w_i_l) begin
      bht_q        <= {BHT_DEPTH{2'b01}};
      res_valid_q  <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      cnt_q        <= '0;
    end else if (bp.flush_w_i_h) begin
      res_valid_q <= 1'b0;
    end else if (!bp.stall_w_i_h) begin
      res_valid_q <= bp.valid_w_i_h;
      if (bp.valid_w_i_h) begin
        taken_q      <= taken_c;
        mispredict_q <= mispredict_c;
        illegal_q    <= ~legal_c;
        if (legal_c) bht_q[upd_idx_c] <= ctr_next_c;
        if (mispredict_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bp.res_valid_w_o_h    = res_valid_q;
  assign bp.taken_w_o_h        = taken_q;
  assign bp.mispredict_w_o_h   = mispredict_q;
  assign bp.illegal_w_o_h      = illegal_q;
  assign bp.mispredict_cnt_w_o = cnt_q;
endmodule
